bullet_ctrl: RTL and testbench

//  Player-bullet controller, directly upstream of the invaders block.
//  - Launches one bullet from the player column on a fire press.
//  - Steps the bullet up the 20x16 playfield grid at a timed rate.
//  - Drives o_bullet_x/o_bullet_y into invaders and consumes its hit flag.
//  - Keeps a 2-digit BCD score.

---
 rtl/bullet_ctrl_pkg.sv | 38 +++
 rtl/bullet_ctrl_timer.sv | 52 +++++
 rtl/bullet_ctrl.sv | 144 ++++++++++++++
 tb/tb_bullet_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_ctrl_pkg.sv
// Shared playfield geometry, bullet FSM encoding and small arithmetic helpers
// for the player-bullet controller.
package bullet_ctrl_pkg;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 16;
    localparam int COL_W     = 5;
    localparam int ROW_W     = 4;
    localparam int SCORE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_FLYING   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    // Two-digit BCD increment; 99 wraps to 00 without any binary intermediate.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [3:0] units;
        logic [3:0] tens;
        units = v[3:0];
        tens  = v[7:4];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W-1:0] x,
                                                   input logic [COL_W-1:0] max_x);
        return (x > max_x) ? max_x : x;
    endfunction

endpackage

// File: rtl/bullet_ctrl_timer.sv
// Free-running step timer: one-cycle registered tick every PERIOD_US
// microseconds, derived from CLKS_PER_US system clocks per microsecond.
module timer_1us
    import bullet_ctrl_pkg::*;
#(
    parameter int PERIOD_US   = 20000,
    parameter int CLKS_PER_US = 36
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int US_W  = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int PER_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam logic [US_W-1:0]  US_LAST  = US_W'(CLKS_PER_US - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_US - 1);

    logic [US_W-1:0]  us_cnt_q,  us_cnt_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic             tick_q,    tick_d;

    always_comb begin
        us_cnt_d  = us_cnt_q + US_W'(1);
        per_cnt_d = per_cnt_q;
        tick_d    = 1'b0;
        if (us_cnt_q == US_LAST) begin
            us_cnt_d = '0;
            if (per_cnt_q == PER_LAST) begin
                per_cnt_d = '0;
                tick_d    = 1'b1;
            end else begin
                per_cnt_d = per_cnt_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            us_cnt_q  <= '0;
            per_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            us_cnt_q  <= us_cnt_d;
            per_cnt_q <= per_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/bullet_ctrl.sv
// Player-bullet controller: launches one bullet from the player column, steps
// it up the grid on timer ticks, consumes the invaders hit flag, keeps a BCD score.
module bullet_ctrl
    import bullet_ctrl_pkg::*;
#(
    parameter int BULLET_SPEED   = 20000,
    parameter int START_Y        = GRID_ROWS - 2,
    parameter int COOLDOWN_TICKS = 2,
    parameter int MAX_X          = GRID_COLS - 1,
    parameter int CLKS_PER_US    = 36
) (
    input  logic         i_clk_36MHz,
    input  logic         i_reset,
    input  logic         i_fire,
    input  logic [4:0]   i_player_x,
    input  logic         i_hit,
    output logic [4:0]   o_bullet_x,
    output logic [3:0]   o_bullet_y,
    output logic         o_bullet_active,
    output logic [7:0]   o_score
);

    localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam logic [CD_W-1:0]  CD_LAST = CD_W'(COOLDOWN_TICKS - 1);
    localparam logic [COL_W-1:0] X_MAX   = COL_W'(MAX_X);
    localparam logic [ROW_W-1:0] Y_START = ROW_W'(START_Y);

    logic step_tick;

    timer_1us #(
        .PERIOD_US   (BULLET_SPEED),
        .CLKS_PER_US (CLKS_PER_US)
    ) u_step_timer (
        .i_clk   (i_clk_36MHz),
        .i_reset (i_reset),
        .o_tick  (step_tick)
    );

    logic               fire_s1_q,   fire_s1_d;
    logic               fire_s2_q,   fire_s2_d;
    logic               fire_s3_q,   fire_s3_d;
    logic               fire_edge_q, fire_edge_d;
    state_e             state_q,     state_d;
    logic [COL_W-1:0]   x_q,         x_d;
    logic [ROW_W-1:0]   y_q,         y_d;
    logic               active_q,    active_d;
    logic [SCORE_W-1:0] score_q,     score_d;
    logic [CD_W-1:0]    cd_cnt_q,    cd_cnt_d;

    always_comb begin
        // i_fire is asynchronous: two sync flops, then a registered rising edge.
        fire_s1_d   = i_fire;
        fire_s2_d   = fire_s1_q;
        fire_s3_d   = fire_s2_q;
        fire_edge_d = fire_s2_q & ~fire_s3_q;

        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        score_d  = score_q;
        cd_cnt_d = cd_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (fire_edge_q) begin
                    state_d  = ST_LAUNCH;
                    x_d      = clamp_col(i_player_x, X_MAX);
                    y_d      = Y_START;
                    active_d = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_FLYING;
            end
            ST_FLYING: begin
                // A hit outranks a coincident step, so y is not decremented then.
                if (i_hit) begin
                    state_d  = ST_COOLDOWN;
                    x_d      = '0;
                    y_d      = '0;
                    active_d = 1'b0;
                    score_d  = bcd_inc(score_q);
                    cd_cnt_d = '0;
                end else if (step_tick) begin
                    if (y_q == '0) begin
                        state_d  = ST_COOLDOWN;
                        x_d      = '0;
                        y_d      = '0;
                        active_d = 1'b0;
                        cd_cnt_d = '0;
                    end else begin
                        y_d = y_q - ROW_W'(1);
                    end
                end
            end
            ST_COOLDOWN: begin
                if (step_tick) begin
                    if (cd_cnt_q == CD_LAST) begin
                        state_d  = ST_IDLE;
                        cd_cnt_d = '0;
                    end else begin
                        cd_cnt_d = cd_cnt_q + CD_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
        if (!i_reset) begin
            fire_s1_q   <= 1'b0;
            fire_s2_q   <= 1'b0;
            fire_s3_q   <= 1'b0;
            fire_edge_q <= 1'b0;
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            active_q    <= 1'b0;
            score_q     <= '0;
            cd_cnt_q    <= '0;
        end else begin
            fire_s1_q   <= fire_s1_d;
            fire_s2_q   <= fire_s2_d;
            fire_s3_q   <= fire_s3_d;
            fire_edge_q <= fire_edge_d;
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            active_q    <= active_d;
            score_q     <= score_d;
            cd_cnt_q    <= cd_cnt_d;
        end
    end

    assign o_bullet_x      = x_q;
    assign o_bullet_y      = y_q;
    assign o_bullet_active = active_q;
    assign o_score         = score_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: cycle model of the bullet rules compared every
// negedge, plus directed scenarios with literal expectations.
module tb_bullet_ctrl;

    localparam int SPEED   = 4;
    localparam int CPU     = 2;
    localparam int P       = SPEED * CPU;
    localparam int START_Y = 14;
    localparam int COOL    = 2;
    localparam int MAX_X   = 19;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       fire  = 1'b0;
    logic       hit   = 1'b0;
    logic [4:0] px    = 5'd0;
    logic [4:0] bx;
    logic [3:0] by;
    logic       ba;
    logic [7:0] sc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bullet_ctrl #(
        .BULLET_SPEED   (SPEED),
        .START_Y        (START_Y),
        .COOLDOWN_TICKS (COOL),
        .MAX_X          (MAX_X),
        .CLKS_PER_US    (CPU)
    ) dut (
        .i_clk_36MHz     (clk),
        .i_reset         (rst_n),
        .i_fire          (fire),
        .i_player_x      (px),
        .i_hit           (hit),
        .o_bullet_x      (bx),
        .o_bullet_y      (by),
        .o_bullet_active (ba),
        .o_score         (sc)
    );

    // Behavioural model: mode 0 idle, 1 launch, 2 flying, 3 cooldown.
    int m_edge, m_mode, m_x, m_y, m_active, m_score, m_cool;
    bit hist[5];
    int dut_launches = 0;
    logic prev_ba = 1'b0;

    task automatic model_reset();
        m_edge = 0; m_mode = 0; m_x = 0; m_y = 0; m_active = 0; m_score = 0; m_cool = 0;
        for (int i = 0; i < 5; i++) hist[i] = 1'b0;
    endtask

    task automatic model_clear();
        m_x = 0; m_y = 0; m_active = 0; m_mode = 3; m_cool = 0;
    endtask

    task automatic model_step();
        bit fire_evt, tick_evt;
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = fire;
        m_edge++;
        fire_evt = hist[3] && !hist[4];
        tick_evt = (m_edge > 1) && (((m_edge - 1) % P) == 0);
        case (m_mode)
            0: if (fire_evt) begin
                   m_mode = 1; m_x = (int'(px) > MAX_X) ? MAX_X : int'(px);
                   m_y = START_Y; m_active = 1;
               end
            1: m_mode = 2;
            2: if (hit) begin
                   model_clear(); m_score = (m_score + 1) % 100;
               end else if (tick_evt) begin
                   if (m_y == 0) model_clear();
                   else m_y = m_y - 1;
               end
            default: if (tick_evt) begin
                   m_cool++;
                   if (m_cool == COOL) m_mode = 0;
               end
        endcase
    endtask

    function automatic int exp_score();
        return (m_score / 10) * 16 + (m_score % 10);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            n_tests++;
            if (int'(bx) != m_x || int'(by) != m_y || int'(ba) != m_active || int'(sc) != exp_score()) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t x=%0d/%0d y=%0d/%0d act=%0d/%0d score=%0h/%0h (dut/model)",
                         $time, bx, m_x, by, m_y, ba, m_active, sc, exp_score());
            end
            if (ba && !prev_ba) dut_launches++;
            prev_ba = ba;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fire();
        fire = 1'b1;
        cycles(2);
        fire = 1'b0;
    endtask

    // Bounded wait on DUT outputs; want_y < 0 means any row.
    task automatic wait_for(input string name, input int budget, input int want_active, input int want_y);
        bit met;
        met = 1'b0;
        for (int k = 0; k <= budget; k++) begin
            met = (int'(ba) == want_active) && (want_y < 0 || int'(by) == want_y);
            if (met) break;
            @(negedge clk);
        end
        chk(name, int'(met), 1);
    endtask

    task automatic do_hit();
        pulse_fire();
        wait_for("hit_launch", 8, 1, -1);
        // First hit cycle lands in LAUNCH and must be ignored; the second scores.
        hit = 1'b1;
        cycles(2);
        hit = 1'b0;
        chk("hit_clears", int'(ba), 0);
        cycles(2 * P + 2);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        bit aligned;
        rst_n = 1'b0;
        cycles(3);
        chk("reset_active", int'(ba), 0);
        chk("reset_score", int'(sc), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Launch timing from column 5
        px = 5'd5;
        fire = 1'b1;
        cycles(2);
        fire = 1'b0;
        @(negedge clk);
        chk("launch_n3_idle", int'(ba), 0);
        @(negedge clk);
        chk("launch_active", int'(ba), 1);
        chk("launch_x", int'(bx), 5);
        chk("launch_y", int'(by), 14);
        wait_for("first_step", 2 * P, 1, 13);
        chk("first_step_x", int'(bx), 5);

        // Hit coincident with a step tick at row 9
        aligned = 1'b0;
        for (int k = 0; k < 10 * P; k++) begin
            if (ba && by == 4'd9 && (m_edge % P) == 0) begin aligned = 1'b1; break; end
            @(negedge clk);
        end
        chk("hit_align", int'(aligned), 1);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        chk("hit_active", int'(ba), 0);
        chk("hit_y", int'(by), 0);
        chk("hit_score", int'(sc), 8'h01);
        cycles(2 * P + 2);

        // Clamp and top exit
        px = 5'd27;
        pulse_fire();
        wait_for("clamp_launch", 8, 1, -1);
        chk("clamp_x", int'(bx), 19);
        chk("clamp_y", int'(by), 14);
        wait_for("top_row0", 16 * P, 1, 0);
        wait_for("top_exit", P + 2, 0, -1);
        chk("exit_score", int'(sc), 8'h01);
        chk("exit_y", int'(by), 0);
        pulse_fire();
        cycles(2 * P);
        chk("cooldown_drop", int'(ba), 0);
        px = 5'd3;
        pulse_fire();
        wait_for("after_cool_launch", 8, 1, -1);
        chk("after_cool_x", int'(bx), 3);

        // Async reset mid-flight at row 7
        wait_for("reach_y7", 10 * P, 1, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_active", int'(ba), 0);
        chk("async_x", int'(bx), 0);
        chk("async_y", int'(by), 0);
        chk("async_score", int'(sc), 0);
        cycles(3);
        #2 rst_n = 1'b1;
        cycles(3);
        chk("post_reset_idle", int'(ba), 0);
        chk("post_reset_score", int'(sc), 0);

        // Score run through 09->10 and 99->00
        px = 5'd10;
        for (int h = 1; h <= 100; h++) begin
            do_hit();
            if (h == 9)   chk("score_09", int'(sc), 8'h09);
            if (h == 10)  chk("score_10", int'(sc), 8'h10);
            if (h == 99)  chk("score_99", int'(sc), 8'h99);
            if (h == 100) chk("score_wrap", int'(sc), 8'h00);
        end

        // Fire held high: one launch only
        base = dut_launches;
        fire = 1'b1;
        cycles(20 * P);
        fire = 1'b0;
        chk("held_fire_launches", dut_launches - base, 1);
        cycles(4);
        pulse_fire();
        wait_for("repulse_launch", 8, 1, -1);
        for (int i = 0; i < 10; i++) begin
            pulse_fire();
            cycles(8);
        end
        wait_for("repulse_exit", 16 * P, 0, -1);
        pulse_fire();
        cycles(2 * P + 4);
        chk("repulse_launches", dut_launches - base, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
